// File: rtl/imul_mac_stage.sv
// imul_mac_stage: multiply-accumulate stage built around a combinational
// NUM_BITS x NUM_BITS array multiplier.
//
// Ports:
//   Clock      rising-edge clock
//   Reset      synchronous, active-high reset
//   iValid     upstream operand pair valid
//   oReady     stage can accept an operand pair (IDLE/ACCUM only)
//   iA, iB     unsigned operands
//   iLast      final element of the current vector
//   oValid     result valid, held until iReady
//   iReady     downstream accepts the result
//   oAcc       accumulated sum of products (modulo 2^ACC_BITS)
//   oCount     elements in the vector, saturating
//   oOverflow  sticky: accumulator wrapped during this vector
//
// Pipeline: S1 operand regs -> S2 product reg -> accumulator.
// ACC_BITS must be >= 2*NUM_BITS.
//
// state | meaning
// IDLE  | waiting for the first element of a vector
// ACCUM | vector open, accepting further elements
// DRAIN | last element accepted, waiting for it to reach the accumulator
// DONE  | result presented, waiting for downstream handoff

module imul_array #(
    parameter int NUM_BITS = 16
) (
    input  logic [NUM_BITS-1:0]   iA,
    input  logic [NUM_BITS-1:0]   iB,
    output logic [2*NUM_BITS-1:0] oP
);
    // Shift-and-add array of partial products.
    always_comb begin
        oP = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            if (iB[i]) begin
                oP = oP + ({{NUM_BITS{1'b0}}, iA} << i);
            end
        end
    end
endmodule

module imul_mac_stage #(
    parameter int NUM_BITS = 16,
    parameter int ACC_BITS = 40,
    parameter int CNT_BITS = 8
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                iValid,
    output logic                oReady,
    input  logic [NUM_BITS-1:0] iA,
    input  logic [NUM_BITS-1:0] iB,
    input  logic                iLast,
    output logic                oValid,
    input  logic                iReady,
    output logic [ACC_BITS-1:0] oAcc,
    output logic [CNT_BITS-1:0] oCount,
    output logic                oOverflow
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                r_state;

    logic [NUM_BITS-1:0]   r_a;
    logic [NUM_BITS-1:0]   r_b;
    logic                  r_s1_valid;
    logic                  r_s1_first;
    logic                  r_s1_last;

    logic [2*NUM_BITS-1:0] r_prod;
    logic                  r_s2_valid;
    logic                  r_s2_first;
    logic                  r_s2_last;

    logic [ACC_BITS-1:0]   r_acc;
    logic [CNT_BITS-1:0]   r_count;
    logic                  r_ovf;
    logic                  r_valid;

    logic                  w_accept;
    logic [2*NUM_BITS-1:0] w_prod;
    logic [ACC_BITS:0]     w_sum;

    imul_array #(.NUM_BITS(NUM_BITS)) u_mul (
        .iA (r_a),
        .iB (r_b),
        .oP (w_prod)
    );

    assign oReady   = (r_state == IDLE) || (r_state == ACCUM);
    assign w_accept = iValid && oReady;

    // Extra top bit captures the carry-out of the accumulate.
    assign w_sum = {1'b0, r_acc} + (ACC_BITS+1)'(r_prod);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_prod     <= '0;
            r_s2_valid <= 1'b0;
            r_s2_first <= 1'b0;
            r_s2_last  <= 1'b0;
            r_acc      <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_a        <= iA;
                r_b        <= iB;
                r_s1_first <= (r_state == IDLE);
                r_s1_last  <= iLast;
            end

            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_prod     <= w_prod;
                r_s2_first <= r_s1_first;
                r_s2_last  <= r_s1_last;
            end

            if (r_s2_valid) begin
                if (r_s2_first) begin
                    r_acc   <= ACC_BITS'(r_prod);
                    r_count <= CNT_BITS'(1);
                    r_ovf   <= 1'b0;
                end else begin
                    r_acc   <= w_sum[ACC_BITS-1:0];
                    r_count <= (r_count == '1) ? r_count : r_count + 1'b1;
                    r_ovf   <= r_ovf | w_sum[ACC_BITS];
                end
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state <= iLast ? DRAIN : ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_accept && iLast) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (r_s2_valid && r_s2_last) begin
                        r_state <= DONE;
                        r_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (r_valid && iReady) begin
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign oValid    = r_valid;
    assign oAcc      = r_acc;
    assign oCount    = r_count;
    assign oOverflow = r_ovf;
endmodule

// File: tb/tb_imul_mac_stage.sv
// Testbench for imul_mac_stage, built with ACC_BITS=32 and CNT_BITS=2 so the
// wrap and count-saturation corners are reachable with short vectors.
module tb_imul_mac_stage;
    localparam int NB = 16;
    localparam int AB = 32;
    localparam int CB = 2;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          iValid;
    logic          oReady;
    logic [NB-1:0] iA;
    logic [NB-1:0] iB;
    logic          iLast;
    logic          oValid;
    logic          iReady;
    logic [AB-1:0] oAcc;
    logic [CB-1:0] oCount;
    logic          oOverflow;

    int n_tests = 0;
    int n_fail  = 0;

    imul_mac_stage #(.NUM_BITS(NB), .ACC_BITS(AB), .CNT_BITS(CB)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .iValid    (iValid),
        .oReady    (oReady),
        .iA        (iA),
        .iB        (iB),
        .iLast     (iLast),
        .oValid    (oValid),
        .iReady    (iReady),
        .oAcc      (oAcc),
        .oCount    (oCount),
        .oOverflow (oOverflow)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int            n;
        logic [NB-1:0] a [6];
        logic [NB-1:0] b [6];
        logic [AB-1:0] acc;
        int            cnt;
        logic          ovf;
    } vec_t;

    vec_t          tbl [6];
    logic [NB-1:0] va [8];
    logic [NB-1:0] vb [8];

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic put(input int t, input int i, input int a, input int b);
        tbl[t].a[i] = NB'(a);
        tbl[t].b[i] = NB'(b);
    endtask

    // Behavioural model: plain arithmetic over the element list.
    task automatic model(input int n, output logic [AB-1:0] acc, output int cnt, output logic ovf);
        longint unsigned s;
        longint unsigned p;
        s   = 0;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            p = longint'(va[i]) * longint'(vb[i]);
            if (i == 0) begin
                s = p;
            end else begin
                s = s + p;
                if (s >= (64'd1 << AB)) begin
                    ovf = 1'b1;
                    s   = s - (64'd1 << AB);
                end
            end
        end
        acc = AB'(s);
        cnt = (n > (1 << CB) - 1) ? (1 << CB) - 1 : n;
    endtask

    // Send va/vb[0..n-1], check latency and result, hold off handoff for bp cycles.
    task automatic run_vec(input int n, input int gaps, input int bp,
                           input logic [AB-1:0] e_acc, input int e_cnt, input logic e_ovf);
        int lat;
        iReady = (bp == 0);
        for (int i = 0; i < n; i++) begin
            while (gaps != 0 && $urandom_range(0, 2) == 0) begin
                iValid = 1'b0;
                step();
            end
            iValid = 1'b1;
            iA     = va[i];
            iB     = vb[i];
            iLast  = (i == n - 1);
            chk("ready_accept", oReady, 1);
            step();
        end
        iValid = 1'b0;
        iLast  = 1'b0;
        lat = 0;
        while (!oValid && lat < 20) begin
            chk("ready_drain", oReady, 0);
            step();
            lat++;
        end
        chk("latency", lat, 2);
        if (oValid) begin
            chk("acc", oAcc, e_acc);
            chk("count", oCount, e_cnt);
            chk("ovf", oOverflow, e_ovf);
            chk("ready_done", oReady, 0);
        end
        for (int k = 0; k < bp; k++) begin
            step();
            chk("bp_valid", oValid, 1);
            chk("bp_acc", oAcc, e_acc);
            chk("bp_ready", oReady, 0);
        end
        iReady = 1'b1;
        step();
        chk("handoff_valid", oValid, 0);
        chk("handoff_ready", oReady, 1);
    endtask

    initial begin
        logic [AB-1:0] m_acc;
        int            m_cnt;
        logic          m_ovf;
        int            n;

        Reset  = 1'b1;
        iValid = 1'b0;
        iA     = '0;
        iB     = '0;
        iLast  = 1'b0;
        iReady = 1'b0;

        tbl[0].n = 1; put(0, 0, 3, 5);
        tbl[0].acc = 32'd15; tbl[0].cnt = 1; tbl[0].ovf = 1'b0;
        tbl[1].n = 3; put(1, 0, 2, 3); put(1, 1, 4, 5); put(1, 2, 6, 7);
        tbl[1].acc = 32'd68; tbl[1].cnt = 3; tbl[1].ovf = 1'b0;
        tbl[2].n = 2; put(2, 0, 16'hFFFF, 16'hFFFF); put(2, 1, 16'hFFFF, 16'hFFFF);
        tbl[2].acc = 32'hFFFC0002; tbl[2].cnt = 2; tbl[2].ovf = 1'b1;
        tbl[3].n = 1; put(3, 0, 1, 1);
        tbl[3].acc = 32'd1; tbl[3].cnt = 1; tbl[3].ovf = 1'b0;
        tbl[4].n = 5; for (int i = 0; i < 5; i++) put(4, i, 1, 1);
        tbl[4].acc = 32'd5; tbl[4].cnt = 3; tbl[4].ovf = 1'b0;
        tbl[5].n = 4; put(5, 0, 100, 200); put(5, 1, 300, 400); put(5, 2, 0, 5); put(5, 3, 65535, 1);
        tbl[5].acc = 32'd205535; tbl[5].cnt = 3; tbl[5].ovf = 1'b0;

        step();
        step();
        Reset = 1'b0;
        chk("rst_valid", oValid, 0);
        chk("rst_acc", oAcc, 0);
        chk("rst_count", oCount, 0);
        chk("rst_ovf", oOverflow, 0);
        chk("rst_ready", oReady, 1);

        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < tbl[t].n; i++) begin
                va[i] = tbl[t].a[i];
                vb[i] = tbl[t].b[i];
            end
            run_vec(tbl[t].n, 0, 0, tbl[t].acc, tbl[t].cnt, tbl[t].ovf);
        end

        // Backpressure: result held while upstream keeps offering an element.
        va[0] = 7; vb[0] = 8;
        iReady = 1'b0;
        iValid = 1'b1; iA = 7; iB = 8; iLast = 1'b1;
        step();
        iValid = 1'b0; iLast = 1'b0;
        step();
        step();
        chk("bp_seq_valid0", oValid, 1);
        iValid = 1'b1; iA = 9; iB = 9; iLast = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("bp_seq_valid", oValid, 1);
            chk("bp_seq_acc", oAcc, 56);
            chk("bp_seq_count", oCount, 1);
            chk("bp_seq_ready", oReady, 0);
            step();
        end
        iValid = 1'b0; iLast = 1'b0;
        iReady = 1'b1;
        step();
        chk("bp_seq_handoff", oValid, 0);
        va[0] = 2; vb[0] = 2;
        run_vec(1, 0, 0, 32'd4, 1, 1'b0);

        // Reset mid-vector discards in-flight elements.
        iReady = 1'b0;
        iValid = 1'b1; iA = 10; iB = 10; iLast = 1'b0;
        step();
        iA = 20; iB = 20;
        step();
        iValid = 1'b0;
        Reset  = 1'b1;
        step();
        Reset  = 1'b0;
        chk("midrst_valid", oValid, 0);
        chk("midrst_acc", oAcc, 0);
        chk("midrst_count", oCount, 0);
        chk("midrst_ready", oReady, 1);
        step();
        step();
        chk("midrst_quiet", oValid, 0);
        va[0] = 1; vb[0] = 2;
        run_vec(1, 0, 0, 32'd2, 1, 1'b0);

        // Random vectors against the model, with input gaps and backpressure.
        for (int r = 0; r < 40; r++) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    va[i] = 16'hFFFF - NB'($urandom_range(0, 3));
                    vb[i] = 16'hFFFF - NB'($urandom_range(0, 3));
                end else begin
                    va[i] = NB'($urandom_range(0, 65535));
                    vb[i] = NB'($urandom_range(0, 65535));
                end
            end
            model(n, m_acc, m_cnt, m_ovf);
            run_vec(n, 1, $urandom_range(0, 3), m_acc, m_cnt, m_ovf);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
